// File: rtl/twi_define.sv
// ----------------------------------------------------------------------------
// twi_define
// Shared definitions for the TWI (I2C) target: the bus state encoding, the
// default target address, and a 3-input majority helper that the optional
// glitch filter uses.
// ----------------------------------------------------------------------------
package twi_define;

    // Bus-side protocol states of the target.
    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8,
        IGNORE    = 4'd9
    } twi_state_e;

    localparam logic [6:0]  TWI_DEFAULT_ADDR = 7'h50;
    localparam int unsigned TWI_DEFAULT_NREG = 8;

    // Majority vote of three samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/twi_target_sync.sv
// ----------------------------------------------------------------------------
// twi_target_sync
// Brings the raw SCL/SDA pad inputs into the CLK_I domain and derives the
// bus events the target state machine works on.
//
// Optional build macro: TWI_TARGET_GLITCH_FILTER_EN
//   defined   : each synchronised line passes a 3-sample majority filter
//               (one extra cycle of latency, single-cycle glitches rejected)
//   undefined : the 2-FF synchroniser output is used directly
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   scl_raw    in   SCL pad input
//   sda_raw    in   SDA pad input
//   sda        out  clean SDA level (for sampling on SCL rise)
//   start_det  out  one-cycle pulse: SDA fell while SCL high
//   stop_det   out  one-cycle pulse: SDA rose while SCL high
//   scl_rise   out  one-cycle pulse: SCL rising edge (sample point)
//   scl_fall   out  one-cycle pulse: SCL falling edge (drive point)
// ----------------------------------------------------------------------------
module twi_target_sync
    import twi_define::*;
(
    input  logic clk,
    input  logic rst,
    input  logic scl_raw,
    input  logic sda_raw,
    output logic sda,
    output logic start_det,
    output logic stop_det,
    output logic scl_rise,
    output logic scl_fall
);

    logic scl_meta_r;
    logic scl_sync_r;
    logic sda_meta_r;
    logic sda_sync_r;
    logic scl_lvl_s;
    logic sda_lvl_s;
    logic scl_prev_r;
    logic sda_prev_r;

    // Two-flop synchronisers; idle bus level is high, so reset to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_meta_r <= 1'b1;
            scl_sync_r <= 1'b1;
            sda_meta_r <= 1'b1;
            sda_sync_r <= 1'b1;
        end else begin
            scl_meta_r <= scl_raw;
            scl_sync_r <= scl_meta_r;
            sda_meta_r <= sda_raw;
            sda_sync_r <= sda_meta_r;
        end
    end

`ifdef TWI_TARGET_GLITCH_FILTER_EN
    logic scl_d1_r;
    logic scl_d2_r;
    logic sda_d1_r;
    logic sda_d2_r;

    // Sample history for the majority filter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_d1_r <= 1'b1;
            scl_d2_r <= 1'b1;
            sda_d1_r <= 1'b1;
            sda_d2_r <= 1'b1;
        end else begin
            scl_d1_r <= scl_sync_r;
            scl_d2_r <= scl_d1_r;
            sda_d1_r <= sda_sync_r;
            sda_d2_r <= sda_d1_r;
        end
    end

    // A level must be seen on two of three consecutive samples to pass.
    assign scl_lvl_s = maj3(scl_sync_r, scl_d1_r, scl_d2_r);
    assign sda_lvl_s = maj3(sda_sync_r, sda_d1_r, sda_d2_r);
`else
    assign scl_lvl_s = scl_sync_r;
    assign sda_lvl_s = sda_sync_r;
`endif

    // Previous clean levels for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_prev_r <= scl_lvl_s;
            sda_prev_r <= sda_lvl_s;
        end
    end

    // START/STOP require SCL high on both the old and new sample so that an
    // SDA change coinciding with an SCL edge is treated as data, not a
    // bus condition.
    assign sda       = sda_lvl_s;
    assign start_det = sda_prev_r & ~sda_lvl_s & scl_lvl_s & scl_prev_r;
    assign stop_det  = ~sda_prev_r & sda_lvl_s & scl_lvl_s & scl_prev_r;
    assign scl_rise  = scl_lvl_s & ~scl_prev_r;
    assign scl_fall  = ~scl_lvl_s & scl_prev_r;

endmodule

// File: rtl/twi_target.sv
// ----------------------------------------------------------------------------
// twi_target
// I2C (TWI) target answering one 7-bit address and exposing NREG 8-bit
// registers. The master writes a pointer byte followed by data bytes
// (auto-increment); reads start at the current pointer and advance on each
// master ACK. The pointer persists between transactions. A local port gives
// the SoC side access to the same bank; an I2C commit wins a same-cycle
// collision with a local write to the same register.
//
// Optional build macro: TWI_TARGET_GLITCH_FILTER_EN (majority filter on the
// synchronised SCL/SDA, see twi_target_sync).
//
// Ports:
//   CLK_I      in   system clock (>= 16x SCL rate)
//   RST_I      in   asynchronous active-high reset
//   SCL_I      in   raw SCL pad input
//   SDA_I      in   raw SDA pad input
//   SDA_OEN    out  0 = pull SDA low, 1 = release
//   REG_WE     in   local write strobe
//   REG_ADR    in   local register address (PW bits)
//   REG_DAT_I  in   local write data
//   REG_DAT_O  out  local read data, one cycle after REG_ADR
//   WR_STB     out  one-cycle pulse per byte committed from the bus
//   WR_ADR     out  register index belonging to WR_STB
//   BUSY       out  high from address ACK until STOP, START or read NACK
// ----------------------------------------------------------------------------
module twi_target
    import twi_define::*;
#(
    parameter logic [6:0] SLV_ADDR = TWI_DEFAULT_ADDR,
    parameter int         NREG     = TWI_DEFAULT_NREG,
    localparam int        PW       = $clog2(NREG)
)(
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic          SCL_I,
    input  logic          SDA_I,
    output logic          SDA_OEN,
    input  logic          REG_WE,
    input  logic [PW-1:0] REG_ADR,
    input  logic [7:0]    REG_DAT_I,
    output logic [7:0]    REG_DAT_O,
    output logic          WR_STB,
    output logic [PW-1:0] WR_ADR,
    output logic          BUSY
);

    localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);

    logic          sda_s;
    logic          start_s;
    logic          stop_s;
    logic          rise_s;
    logic          fall_s;

    twi_state_e    state_r;
    twi_state_e    state_nxt_s;
    logic [3:0]    bit_cnt_r;
    logic [7:0]    shift_r;
    logic [7:0]    tx_r;
    logic [PW-1:0] ptr_r;
    logic [7:0]    regs_r [NREG];

    logic          sda_oen_r;
    logic          busy_r;
    logic          wr_stb_r;
    logic [PW-1:0] wr_adr_r;
    logic [7:0]    reg_dat_r;

    logic [7:0]    rx_byte_s;
    logic [7:0]    rd_byte_s;
    logic          addr_match_s;
    logic          last_bit_s;
    logic          byte_end_s;

    logic          sda_oen_nxt_s;
    logic          busy_nxt_s;
    logic          cnt_clr_s;
    logic          cnt_inc_s;
    logic          rx_shift_s;
    logic          ptr_load_s;
    logic          ptr_inc_s;
    logic          commit_s;
    logic          tx_load_s;
    logic          tx_shift_s;

    twi_target_sync u_sync (
        .clk       (CLK_I),
        .rst       (RST_I),
        .scl_raw   (SCL_I),
        .sda_raw   (SDA_I),
        .sda       (sda_s),
        .start_det (start_s),
        .stop_det  (stop_s),
        .scl_rise  (rise_s),
        .scl_fall  (fall_s)
    );

    // rx_byte_s is the complete byte as of the 8th SCL rise (current SDA as LSB).
    assign rx_byte_s    = {shift_r[6:0], sda_s};
    assign rd_byte_s    = regs_r[ptr_r];
    assign addr_match_s = (shift_r[7:1] == SLV_ADDR);
    assign last_bit_s   = (bit_cnt_r == 4'd7);
    assign byte_end_s   = (bit_cnt_r == 4'd8);

    // State register.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; START/STOP override whatever the state machine is doing.
    always_comb begin
        state_nxt_s = state_r;
        if (start_s) begin
            state_nxt_s = ADDR;
        end else if (stop_s) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE:      state_nxt_s = IDLE;
                ADDR: begin
                    if (fall_s && byte_end_s) begin
                        state_nxt_s = addr_match_s ? ADDR_ACK : IGNORE;
                    end else begin
                        state_nxt_s = ADDR;
                    end
                end
                ADDR_ACK: begin
                    if (fall_s) begin
                        state_nxt_s = shift_r[0] ? RDATA : PTR;
                    end else begin
                        state_nxt_s = ADDR_ACK;
                    end
                end
                PTR:       state_nxt_s = (fall_s && byte_end_s) ? PTR_ACK : PTR;
                PTR_ACK:   state_nxt_s = fall_s ? WDATA : PTR_ACK;
                WDATA:     state_nxt_s = (fall_s && byte_end_s) ? WDATA_ACK : WDATA;
                WDATA_ACK: state_nxt_s = fall_s ? WDATA : WDATA_ACK;
                RDATA:     state_nxt_s = (fall_s && byte_end_s) ? RDATA_ACK : RDATA;
                RDATA_ACK: begin
                    if (rise_s && sda_s) begin
                        state_nxt_s = IGNORE;
                    end else if (fall_s) begin
                        state_nxt_s = RDATA;
                    end else begin
                        state_nxt_s = RDATA_ACK;
                    end
                end
                IGNORE:    state_nxt_s = IGNORE;
                default:   state_nxt_s = IDLE;
            endcase
        end
    end

    // Output/control decode. SDA_OEN only moves on an SCL fall, so the
    // target never changes SDA while SCL is high.
    always_comb begin
        sda_oen_nxt_s = sda_oen_r;
        busy_nxt_s    = busy_r;
        cnt_clr_s     = 1'b0;
        cnt_inc_s     = 1'b0;
        rx_shift_s    = 1'b0;
        ptr_load_s    = 1'b0;
        ptr_inc_s     = 1'b0;
        commit_s      = 1'b0;
        tx_load_s     = 1'b0;
        tx_shift_s    = 1'b0;
        if (start_s || stop_s) begin
            sda_oen_nxt_s = 1'b1;
            busy_nxt_s    = 1'b0;
            cnt_clr_s     = 1'b1;
        end else begin
            case (state_r)
                ADDR: begin
                    if (rise_s && !byte_end_s) begin
                        rx_shift_s = 1'b1;
                        cnt_inc_s  = 1'b1;
                    end else if (fall_s && byte_end_s && addr_match_s) begin
                        sda_oen_nxt_s = 1'b0;
                        busy_nxt_s    = 1'b1;
                    end else begin
                        sda_oen_nxt_s = sda_oen_r;
                    end
                end
                PTR: begin
                    if (rise_s && !byte_end_s) begin
                        rx_shift_s = 1'b1;
                        cnt_inc_s  = 1'b1;
                        ptr_load_s = last_bit_s;
                    end else if (fall_s && byte_end_s) begin
                        sda_oen_nxt_s = 1'b0;
                    end else begin
                        sda_oen_nxt_s = sda_oen_r;
                    end
                end
                WDATA: begin
                    if (rise_s && !byte_end_s) begin
                        rx_shift_s = 1'b1;
                        cnt_inc_s  = 1'b1;
                        commit_s   = last_bit_s;
                        ptr_inc_s  = last_bit_s;
                    end else if (fall_s && byte_end_s) begin
                        sda_oen_nxt_s = 1'b0;
                    end else begin
                        sda_oen_nxt_s = sda_oen_r;
                    end
                end
                ADDR_ACK: begin
                    if (fall_s) begin
                        cnt_clr_s = 1'b1;
                        if (shift_r[0]) begin
                            // Read: first data bit goes out on the same fall that ends the ACK.
                            tx_load_s     = 1'b1;
                            sda_oen_nxt_s = rd_byte_s[7];
                        end else begin
                            sda_oen_nxt_s = 1'b1;
                        end
                    end else begin
                        sda_oen_nxt_s = sda_oen_r;
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (fall_s) begin
                        sda_oen_nxt_s = 1'b1;
                        cnt_clr_s     = 1'b1;
                    end else begin
                        sda_oen_nxt_s = sda_oen_r;
                    end
                end
                RDATA: begin
                    if (rise_s && !byte_end_s) begin
                        cnt_inc_s = 1'b1;
                    end else if (fall_s && byte_end_s) begin
                        sda_oen_nxt_s = 1'b1;
                    end else if (fall_s) begin
                        tx_shift_s    = 1'b1;
                        sda_oen_nxt_s = tx_r[7];
                    end else begin
                        sda_oen_nxt_s = sda_oen_r;
                    end
                end
                RDATA_ACK: begin
                    if (rise_s && sda_s) begin
                        busy_nxt_s = 1'b0;
                    end else if (rise_s) begin
                        ptr_inc_s = 1'b1;
                    end else if (fall_s) begin
                        // Pointer already advanced on the ACK rise.
                        tx_load_s     = 1'b1;
                        cnt_clr_s     = 1'b1;
                        sda_oen_nxt_s = rd_byte_s[7];
                    end else begin
                        sda_oen_nxt_s = sda_oen_r;
                    end
                end
                IDLE, IGNORE: begin
                    sda_oen_nxt_s = 1'b1;
                end
                default: begin
                    sda_oen_nxt_s = 1'b1;
                    busy_nxt_s    = 1'b0;
                end
            endcase
        end
    end

    // Bit counter, receive/transmit shifters and register pointer.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            bit_cnt_r <= 4'd0;
            shift_r   <= 8'h00;
            tx_r      <= 8'h00;
            ptr_r     <= '0;
        end else begin
            if (cnt_clr_s) begin
                bit_cnt_r <= 4'd0;
            end else if (cnt_inc_s) begin
                bit_cnt_r <= bit_cnt_r + 4'd1;
            end
            if (rx_shift_s) begin
                shift_r <= rx_byte_s;
            end
            // The read byte is captured here so later bank writes cannot disturb it.
            if (tx_load_s) begin
                tx_r <= {rd_byte_s[6:0], 1'b0};
            end else if (tx_shift_s) begin
                tx_r <= {tx_r[6:0], 1'b0};
            end
            if (ptr_load_s) begin
                ptr_r <= rx_byte_s[PW-1:0];
            end else if (ptr_inc_s) begin
                ptr_r <= ptr_r + PTR_ONE;
            end
        end
    end

    // Register bank; the bus commit is written last so it wins a same-register collision.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= 8'h00;
            end
        end else begin
            if (REG_WE) begin
                regs_r[REG_ADR] <= REG_DAT_I;
            end
            if (commit_s) begin
                regs_r[ptr_r] <= rx_byte_s;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            sda_oen_r <= 1'b1;
            busy_r    <= 1'b0;
            wr_stb_r  <= 1'b0;
            wr_adr_r  <= '0;
            reg_dat_r <= 8'h00;
        end else begin
            sda_oen_r <= sda_oen_nxt_s;
            busy_r    <= busy_nxt_s;
            wr_stb_r  <= commit_s;
            if (commit_s) begin
                wr_adr_r <= ptr_r;
            end
            reg_dat_r <= regs_r[REG_ADR];
        end
    end

    assign SDA_OEN   = sda_oen_r;
    assign BUSY      = busy_r;
    assign WR_STB    = wr_stb_r;
    assign WR_ADR    = wr_adr_r;
    assign REG_DAT_O = reg_dat_r;

endmodule

// File: tb/tb_twi_target.sv
// ----------------------------------------------------------------------------
// tb_twi_target
// Directed bench for twi_target: a bit-banged I2C master drives SCL/SDA with
// an open-drain SDA model, and local-port accesses read the bank back.
// ----------------------------------------------------------------------------
module tb_twi_target;

    localparam int PW = 3;
    localparam int Q  = 8;   // CLK_I cycles per quarter SCL period
`ifdef TWI_TARGET_GLITCH_FILTER_EN
    localparam int COMMIT_NE = 3;
`else
    localparam int COMMIT_NE = 2;
`endif

    logic          clk;
    logic          rst;
    logic          scl_m;
    logic          sda_m;
    logic          sda_line;
    logic          sda_oen;
    logic          reg_we;
    logic [PW-1:0] reg_adr;
    logic [7:0]    reg_dat_i;
    logic [7:0]    reg_dat_o;
    logic          wr_stb;
    logic [PW-1:0] wr_adr;
    logic          busy;

    int checks;
    int errors;
    int wr_log[$];
    logic mon_en;
    int   mon_bad;

    assign sda_line = sda_m & sda_oen;

    twi_target dut (
        .CLK_I     (clk),
        .RST_I     (rst),
        .SCL_I     (scl_m),
        .SDA_I     (sda_line),
        .SDA_OEN   (sda_oen),
        .REG_WE    (reg_we),
        .REG_ADR   (reg_adr),
        .REG_DAT_I (reg_dat_i),
        .REG_DAT_O (reg_dat_o),
        .WR_STB    (wr_stb),
        .WR_ADR    (wr_adr),
        .BUSY      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every bus commit and watch for target activity where none is allowed.
    always @(negedge clk) begin
        if (wr_stb === 1'b1) wr_log.push_back(int'(wr_adr));
        if (mon_en && (sda_oen !== 1'b1 || busy !== 1'b0)) mon_bad++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    // One SCL clock: data set while low, sampled mid-high. Optionally injects
    // a one-cycle SCL glitch during the low phase or a local write aligned to
    // the cycle in which the target commits on this rising edge.
    task automatic bit_xfer(input logic b, input logic glitch, input logic we_pulse,
                            output logic sampled);
        sda_m = b;
        if (glitch) begin
            repeat (3) @(negedge clk);
            scl_m = 1'b1;
            @(negedge clk);
            scl_m = 1'b0;
            repeat (Q - 4) @(negedge clk);
        end else begin
            wait_q();
        end
        scl_m = 1'b1;
        if (we_pulse) begin
            repeat (COMMIT_NE) @(negedge clk);
            reg_we = 1'b1;
            @(negedge clk);
            reg_we = 1'b0;
            repeat (Q - COMMIT_NE - 1) @(negedge clk);
        end else begin
            wait_q();
        end
        sampled = sda_line;
        wait_q();
        scl_m = 1'b0;
        wait_q();
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, input logic glitch, input logic we_pulse,
                              output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(b[i], glitch && (i == 4), we_pulse && (i == 0), s);
        end
        bit_xfer(1'b1, 1'b0, 1'b0, ack);
    endtask

    task automatic read_byte(input logic ack_bit, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, 1'b0, 1'b0, s);
            d[i] = s;
        end
        bit_xfer(ack_bit, 1'b0, 1'b0, s);
    endtask

    task automatic local_rd(input logic [PW-1:0] a, output logic [7:0] d);
        @(negedge clk);
        reg_adr = a;
        @(posedge clk);
        #1 d = reg_dat_o;
    endtask

    task automatic local_wr(input logic [PW-1:0] a, input logic [7:0] d);
        @(negedge clk);
        reg_adr   = a;
        reg_dat_i = d;
        reg_we    = 1'b1;
        @(negedge clk);
        reg_we    = 1'b0;
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        checks    = 0;
        errors    = 0;
        mon_en    = 1'b0;
        mon_bad   = 0;
        rst       = 1'b1;
        scl_m     = 1'b1;
        sda_m     = 1'b1;
        reg_we    = 1'b0;
        reg_adr   = 3'd0;
        reg_dat_i = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_sda_oen", {31'd0, sda_oen}, 32'd1);
        check("rst_busy",    {31'd0, busy},    32'd0);
        check("rst_wr_stb",  {31'd0, wr_stb},  32'd0);
        check("rst_wr_adr",  {29'd0, wr_adr},  32'd0);
        check("rst_dat_o",   {24'd0, reg_dat_o}, 32'd0);

        // Pointer write followed by two data bytes
        i2c_start();
        write_byte(8'hA0, 1'b0, 1'b0, ack); check("wr_addr_ack", {31'd0, ack}, 32'd0);
        check("wr_busy_hi", {31'd0, busy}, 32'd1);
        write_byte(8'h02, 1'b0, 1'b0, ack); check("wr_ptr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'hA5, 1'b0, 1'b0, ack); check("wr_d0_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h5A, 1'b0, 1'b0, ack); check("wr_d1_ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        check("wr_busy_lo", {31'd0, busy}, 32'd0);
        check("wr_stb_count", wr_log.size(), 32'd2);
        check("wr_adr_0", wr_log[0], 32'd2);
        check("wr_adr_1", wr_log[1], 32'd3);
        local_rd(3'd2, d); check("reg2", {24'd0, d}, 32'hA5);
        local_rd(3'd3, d); check("reg3", {24'd0, d}, 32'h5A);

        // Pointer set, repeated START, two-byte read
        i2c_start();
        write_byte(8'hA0, 1'b0, 1'b0, ack); check("rd_waddr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h02, 1'b0, 1'b0, ack); check("rd_ptr_ack", {31'd0, ack}, 32'd0);
        i2c_start();
        write_byte(8'hA1, 1'b0, 1'b0, ack); check("rd_raddr_ack", {31'd0, ack}, 32'd0);
        read_byte(1'b0, d); check("rd_byte0", {24'd0, d}, 32'hA5);
        read_byte(1'b1, d); check("rd_byte1", {24'd0, d}, 32'h5A);
        check("rd_nack_release", {31'd0, sda_oen}, 32'd1);
        check("rd_nack_busy", {31'd0, busy}, 32'd0);
        i2c_stop();
        check("rd_no_commit", wr_log.size(), 32'd2);

        // Foreign address: target must stay silent
        mon_en = 1'b1;
        i2c_start();
        write_byte(8'hA2, 1'b0, 1'b0, ack); check("mm_addr_nack", {31'd0, ack}, 32'd1);
        write_byte(8'h00, 1'b0, 1'b0, ack); check("mm_data_nack", {31'd0, ack}, 32'd1);
        i2c_stop();
        mon_en = 1'b0;
        check("mm_silent", mon_bad, 32'd0);
        local_rd(3'd0, d); check("mm_reg0", {24'd0, d}, 32'h00);

        // Pointer wrap NREG-1 -> 0
        i2c_start();
        write_byte(8'hA0, 1'b0, 1'b0, ack);
        write_byte(8'h07, 1'b0, 1'b0, ack);
        write_byte(8'h11, 1'b0, 1'b0, ack); check("wrap_d0_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h22, 1'b0, 1'b0, ack); check("wrap_d1_ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        check("wrap_adr_0", wr_log[2], 32'd7);
        check("wrap_adr_1", wr_log[3], 32'd0);
        local_rd(3'd7, d); check("wrap_reg7", {24'd0, d}, 32'h11);
        local_rd(3'd0, d); check("wrap_reg0", {24'd0, d}, 32'h22);

        // Collision: local write 0x33 and bus commit 0x44 to reg4 in one cycle
        reg_adr   = 3'd4;
        reg_dat_i = 8'h33;
        i2c_start();
        write_byte(8'hA0, 1'b0, 1'b0, ack);
        write_byte(8'h04, 1'b0, 1'b0, ack);
        write_byte(8'h44, 1'b0, 1'b1, ack); check("col_ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        check("col_adr", wr_log[4], 32'd4);
        local_rd(3'd4, d); check("col_reg4", {24'd0, d}, 32'h44);

        // Current-address read starts at the persisted pointer (5)
        local_wr(3'd5, 8'h66);
        i2c_start();
        write_byte(8'hA1, 1'b0, 1'b0, ack); check("cur_addr_ack", {31'd0, ack}, 32'd0);
        read_byte(1'b1, d); check("cur_rd", {24'd0, d}, 32'h66);
        i2c_stop();

`ifdef TWI_TARGET_GLITCH_FILTER_EN
        // SCL glitch in mid-byte must not shift an extra bit
        i2c_start();
        write_byte(8'hA0, 1'b0, 1'b0, ack);
        write_byte(8'h01, 1'b0, 1'b0, ack);
        write_byte(8'h3C, 1'b1, 1'b0, ack); check("glitch_ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        local_rd(3'd1, d); check("glitch_reg1", {24'd0, d}, 32'h3C);
`endif

        // Abort by reset while the target drives a 0 data bit (reg7 = 0x11)
        i2c_start();
        write_byte(8'hA0, 1'b0, 1'b0, ack);
        write_byte(8'h07, 1'b0, 1'b0, ack);
        i2c_start();
        write_byte(8'hA1, 1'b0, 1'b0, ack);
        check("abort_driving", {31'd0, sda_oen}, 32'd0);
        rst = 1'b1;
        #1;
        check("abort_release", {31'd0, sda_oen}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        local_rd(3'd7, d); check("abort_reg7_cleared", {24'd0, d}, 32'h00);

        // Full transaction after the abort
        i2c_start();
        write_byte(8'hA0, 1'b0, 1'b0, ack); check("post_addr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h03, 1'b0, 1'b0, ack);
        write_byte(8'h7E, 1'b0, 1'b0, ack);
        write_byte(8'h81, 1'b0, 1'b0, ack); check("post_wr_ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        i2c_start();
        write_byte(8'hA0, 1'b0, 1'b0, ack);
        write_byte(8'h03, 1'b0, 1'b0, ack);
        i2c_start();
        write_byte(8'hA1, 1'b0, 1'b0, ack); check("post_raddr_ack", {31'd0, ack}, 32'd0);
        read_byte(1'b0, d); check("post_rd0", {24'd0, d}, 32'h7E);
        read_byte(1'b1, d); check("post_rd1", {24'd0, d}, 32'h81);
        i2c_stop();
        check("post_busy", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/twi_target.md
Name: twi_target

Overview:
- I2C (TWI) target/responder: the bus-end counterpart of the master TWI core in the peripheral block.
- Answers one 7-bit address and exposes a bank of NREG 8-bit registers to an external I2C master.
- Supports pointer-based write, current-address read, auto-increment and repeated START.
- A local register port lets the SoC side read and write the same bank; used for board-management and inter-FPGA links.

Parameters:
- SLV_ADDR, 7'h50, target address matched against the first byte after START.
- NREG, 8, register count; power of 2, 2..256; PW = log2(NREG).

Ports:
- CLK_I  in  1  system clock; must be at least 16x the SCL rate.
- RST_I  in  1  reset, asynchronous, active-high.
- SCL_I  in  1  bus clock, raw pad input.
- SDA_I  in  1  bus data, raw pad input.
- SDA_OEN  out  1  0 = drive SDA low, 1 = release SDA.
- REG_WE  in  1  local write strobe.
- REG_ADR  in  PW  local register address.
- REG_DAT_I  in  8  local write data.
- REG_DAT_O  out  8  local read data, registered, 1-cycle latency.
- WR_STB  out  1  one-cycle pulse per byte committed by the I2C master.
- WR_ADR  out  PW  register index for WR_STB.
- BUSY  out  1  high from address ACK until STOP, repeated START or NACK.

Behaviour:
- Reset values: SDA_OEN=1, REG_DAT_O=0, WR_STB=0, WR_ADR=0, BUSY=0, all registers=0, pointer=0, state=IDLE.
- Input sync: SCL and SDA pass through a 2-FF synchroniser that resets to 1.
- Edge detection on synchronised signals:
  - START = SDA fall while SCL high.
  - STOP = SDA rise while SCL high.
  - SCL rise = sample point; SCL fall = drive point.
- START or STOP in any state aborts: shift counter and state reset, SDA_OEN=1, BUSY=0.
  - After STOP: state=IDLE.
  - After START (including repeated START): state=ADDR.
- State machine:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first on SCL rise.
    - bits[7:1]==SLV_ADDR: on the SCL fall after bit 8, drive SDA low (ACK) and set BUSY.
    - Mismatch: release SDA, go to IGNORE.
  - ADDR_ACK: release SDA on the next SCL fall. Next state is PTR if R/W=0, RDATA if R/W=1.
    - RDATA entry: load the read shifter from reg[pointer] and drive its MSB on that same SCL fall.
  - PTR: receive 8 bits; pointer <= byte[PW-1:0] (upper bits ignored); ACK; go to WDATA.
  - WDATA: receive 8 bits; at the 8th SCL rise write reg[pointer], pulse WR_STB with WR_ADR=pointer, pointer increments; ACK; stay in WDATA.
  - RDATA: shift the byte out, changing SDA on SCL fall; release SDA after bit 8; sample the master ACK on the 9th SCL rise.
    - ACK (SDA=0): pointer increments, load the next byte, continue.
    - NACK: go to IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- Pointer arithmetic: wraps modulo NREG (NREG-1 -> 0). The read pointer advances only on master ACK.
- The pointer persists across transactions, so a read with no preceding PTR starts at the last pointer value.
- Read data is latched at byte start; a local write during shifting does not alter the byte in flight.
- Local port:
  - REG_WE writes reg[REG_ADR] on the clock edge.
  - REG_DAT_O <= reg[REG_ADR] every cycle.
- Collision: an I2C commit and REG_WE to the same register in the same cycle resolve I2C-wins; different registers both update.
- SDA_OEN changes only on a detected SCL fall. It is never driven low while SCL is high, except to hold an ACK or data bit.

Optional Feature:
- Macro: TWI_TARGET_GLITCH_FILTER_EN.
- Defined: after the synchroniser, each of SCL and SDA passes a 3-sample majority filter over consecutive CLK_I samples, adding 1 cycle of latency; single-cycle glitches are rejected.
- Undefined: the 2-FF synchroniser output is used directly.
- Filter state resets to 1.

Decomposition:
- Shared package twi_define: state encodings (IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE) and the default SLV_ADDR constant.
- Sub-module twi_target_sync: synchroniser, optional filter, and START/STOP/SCL-rise/SCL-fall pulse generation.

Test Plan:
- Write: START, 0xA0, 0x02, 0xA5, 0x5A, STOP -> ACK on every byte; reg2=0xA5, reg3=0x5A; WR_STB pulses with WR_ADR=2 then 3; BUSY falls on STOP.
- Read: START, 0xA0, 0x02, repeated START, 0xA1, read 2 bytes (ACK then NACK), STOP -> master receives 0xA5, 0x5A; SDA released after the NACK.
- Address mismatch: START, 0xA2, 0x00 -> SDA_OEN stays 1 for the whole transfer; no register change; BUSY=0.
- Wrap: pointer 7, write 0x11, 0x22 -> reg7=0x11, reg0=0x22; then local REG_ADR=0 gives REG_DAT_O=0x22 one cycle later.
- Collision: REG_WE to reg4 with 0x33 in the same cycle as an I2C commit of 0x44 to reg4 -> reg4=0x44.
- Abort: assert RST_I mid-read while driving a 0 bit -> SDA_OEN=1 immediately; a subsequent full transaction succeeds.
- With TWI_TARGET_GLITCH_FILTER_EN: inject 1-cycle SCL pulses mid-byte -> no extra bit shifted and correct data received.
